// File: rtl/if1_btb_pkg.sv
// IF1 BTB shared types: br_type codes, reset PC, BTB entry layout.
// BTB_COUNTER_EN adds a 2-bit direction counter to each entry.
package if1_btb_pkg;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;
  localparam int          TAG_W    = 30;

  localparam logic [1:0] BR_OTHER = 2'b00;
  localparam logic [1:0] BR_COND  = 2'b01;
  localparam logic [1:0] BR_BL    = 2'b10;
  localparam logic [1:0] BR_JIRL  = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [1:0]       btype;
    logic [31:0]      target;
`ifdef BTB_COUNTER_EN
    logic [1:0]       ctr;
`endif
  } btb_entry_t;

`ifdef BTB_COUNTER_EN
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction
`endif

endpackage

// File: rtl/if1_btb_array.sv
// Direct-mapped BTB storage: one lookup read, two RMW ports (EX, IF2).
// EX write is applied after IF2, so EX wins on a shared index.
module btb_array
  import if1_btb_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [IDX_W-1:0] rd_idx,
  output btb_entry_t       rd_entry,
  input  logic [IDX_W-1:0] ex_idx,
  output btb_entry_t       ex_entry,
  input  logic             ex_we,
  input  btb_entry_t       ex_wdata,
  input  logic [IDX_W-1:0] if2_idx,
  output btb_entry_t       if2_entry,
  input  logic             if2_we,
  input  btb_entry_t       if2_wdata
);

  btb_entry_t mem [ENTRIES];

  assign rd_entry  = mem[rd_idx];
  assign ex_entry  = mem[ex_idx];
  assign if2_entry = mem[if2_idx];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++)
        mem[i].valid <= 1'b0;
    end else begin
      if (if2_we) mem[if2_idx] <= if2_wdata;
      if (ex_we)  mem[ex_idx]  <= ex_wdata;
    end
  end

endmodule

// File: rtl/if1_btb.sv
// IF1 fetch PC register with BTB prediction and EX/IF2 BTB updates.
// Ports: clk/rstn, stall, EX redirect+update, IF2 redirect -> pc,
// pc_plus_4, brtype_pcpre. Macro BTB_COUNTER_EN enables 2-bit counters.
module if1_btb
  import if1_btb_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = if1_btb_pkg::RESET_PC,
  parameter int          BTB_ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_pc_target,
  input  logic        ex_upd_en,
  input  logic [31:0] ex_upd_pc,
  input  logic [1:0]  ex_upd_type,
  input  logic [31:0] ex_upd_target,
  input  logic        ex_upd_taken,
  input  logic        if2_redirect,
  input  logic [31:0] if2_pc,
  input  logic [31:0] if2_pc_fact,
  input  logic [33:0] if2_type_pcpre,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic [33:0] brtype_pcpre
);

  localparam int IDX_W   = $clog2(BTB_ENTRIES);
  localparam int TAG_LSB = IDX_W + 2;

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
    return TAG_W'(a >> TAG_LSB);
  endfunction

  logic [31:0]      pc_q;
  logic [31:0]      pc_nxt;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [IDX_W-1:0] if2_idx;
  btb_entry_t       rd_e;
  btb_entry_t       ex_e;
  btb_entry_t       if2_e;
  btb_entry_t       ex_w;
  btb_entry_t       if2_w;
  logic             if2_we;
  logic             hit;
  logic             pred_tk;
  logic [1:0]       if2_type;
  logic             unused_bits;

  assign pc        = pc_q;
  assign pc_plus_4 = pc_q + 32'd4;
  assign rd_idx    = pc_q[TAG_LSB-1:2];
  assign ex_idx    = ex_upd_pc[TAG_LSB-1:2];
  assign if2_idx   = if2_pc[TAG_LSB-1:2];
  assign if2_type  = if2_type_pcpre[33:32];

  assign hit = rd_e.valid && (rd_e.tag == tag_of(pc_q));

`ifdef BTB_COUNTER_EN
  logic ex_hit;
  logic if2_hit;

  assign ex_hit  = ex_e.valid && (ex_e.tag == tag_of(ex_upd_pc));
  assign if2_hit = if2_e.valid && (if2_e.tag == tag_of(if2_pc));
  assign pred_tk = (rd_e.btype == BR_BL) || (rd_e.btype == BR_JIRL)
                || ((rd_e.btype == BR_COND) && rd_e.ctr[1]);
  assign unused_bits = ^{if2_type_pcpre[31:0], ex_upd_pc[1:0]};
`else
  assign pred_tk = 1'b1;
  assign unused_bits = ^{if2_type_pcpre[31:0], ex_upd_pc[1:0],
                         ex_upd_taken};
`endif

  always_comb begin
    brtype_pcpre = {BR_OTHER, pc_plus_4};
    if (hit)
      brtype_pcpre = pred_tk ? {rd_e.btype, rd_e.target}
                             : {rd_e.btype, pc_plus_4};
  end

  always_comb begin
    if (ex_redirect)       pc_nxt = ex_pc_target;
    else if (if2_redirect) pc_nxt = if2_pc_fact;
    else if (stall)        pc_nxt = pc_q;
    else                   pc_nxt = brtype_pcpre[31:0];
  end

  always_ff @(posedge clk) begin
    if (!rstn) pc_q <= RESET_PC;
    else       pc_q <= pc_nxt;
  end

  always_comb begin
    ex_w = ex_e;
    if (ex_upd_type == BR_OTHER) begin
      ex_w.valid = 1'b0;
    end else begin
      ex_w.valid  = 1'b1;
      ex_w.tag    = tag_of(ex_upd_pc);
      ex_w.btype  = ex_upd_type;
      ex_w.target = ex_upd_target;
`ifdef BTB_COUNTER_EN
      if (ex_hit)
        ex_w.ctr = ex_upd_taken ? ctr_inc(ex_e.ctr) : ctr_dec(ex_e.ctr);
      else
        ex_w.ctr = ex_upd_taken ? 2'b10 : 2'b01;
`endif
    end
  end

  // IF2 only confirms a fall-through on a hit: weaken the counter.
  always_comb begin
    if2_w  = if2_e;
    if2_we = 1'b0;
    if (if2_redirect) begin
      if (if2_type == BR_OTHER) begin
        if2_we       = 1'b1;
        if2_w.valid  = 1'b0;
      end else if (if2_pc_fact != if2_pc + 32'd4) begin
        if2_we       = 1'b1;
        if2_w.valid  = 1'b1;
        if2_w.tag    = tag_of(if2_pc);
        if2_w.btype  = if2_type;
        if2_w.target = if2_pc_fact;
`ifdef BTB_COUNTER_EN
        if2_w.ctr    = 2'b10;
      end else if (if2_hit) begin
        if2_we       = 1'b1;
        if2_w.ctr    = ctr_dec(if2_e.ctr);
`endif
      end
    end
  end

  btb_array #(
    .ENTRIES (BTB_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_array (
    .clk       (clk),
    .rstn      (rstn),
    .rd_idx    (rd_idx),
    .rd_entry  (rd_e),
    .ex_idx    (ex_idx),
    .ex_entry  (ex_e),
    .ex_we     (ex_upd_en),
    .ex_wdata  (ex_w),
    .if2_idx   (if2_idx),
    .if2_entry (if2_e),
    .if2_we    (if2_we),
    .if2_wdata (if2_w)
  );

endmodule

// File: tb/tb_if1_btb.sv
// Self-checking bench for if1_btb: directed steps, then random traffic
// checked against a table-level BTB model.
module tb_if1_btb;

`ifdef BTB_COUNTER_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall;
  logic        ex_redirect;
  logic [31:0] ex_pc_target;
  logic        ex_upd_en;
  logic [31:0] ex_upd_pc;
  logic [1:0]  ex_upd_type;
  logic [31:0] ex_upd_target;
  logic        ex_upd_taken;
  logic        if2_redirect;
  logic [31:0] if2_pc;
  logic [31:0] if2_pc_fact;
  logic [33:0] if2_type_pcpre;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic [33:0] brtype_pcpre;

  int total = 0;
  int bad   = 0;

  bit [31:0] m_pc;
  bit        m_v  [64];
  bit [23:0] m_tag[64];
  bit [1:0]  m_ty [64];
  bit [31:0] m_tg [64];
  bit [1:0]  m_ct [64];

  always #5 clk = ~clk;

  if1_btb #(
    .RESET_PC    (32'h1c00_0000),
    .BTB_ENTRIES (64)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .stall          (stall),
    .ex_redirect    (ex_redirect),
    .ex_pc_target   (ex_pc_target),
    .ex_upd_en      (ex_upd_en),
    .ex_upd_pc      (ex_upd_pc),
    .ex_upd_type    (ex_upd_type),
    .ex_upd_target  (ex_upd_target),
    .ex_upd_taken   (ex_upd_taken),
    .if2_redirect   (if2_redirect),
    .if2_pc         (if2_pc),
    .if2_pc_fact    (if2_pc_fact),
    .if2_type_pcpre (if2_type_pcpre),
    .pc             (pc),
    .pc_plus_4      (pc_plus_4),
    .brtype_pcpre   (brtype_pcpre)
  );

  function automatic int ix(input bit [31:0] a);
    return int'((a / 4) % 64);
  endfunction

  function automatic bit hitm(input bit [31:0] a);
    return m_v[ix(a)] && (m_tag[ix(a)] == 24'(a / 256));
  endfunction

  function automatic bit [33:0] predict(input bit [31:0] a);
    int i;
    bit tk;
    i = ix(a);
    if (!hitm(a)) return {2'b00, a + 32'd4};
    tk = CNT ? (m_ty[i] != 2'b01 || m_ct[i][1]) : 1'b1;
    return tk ? {m_ty[i], m_tg[i]} : {m_ty[i], a + 32'd4};
  endfunction

  task automatic chk(input string tag, input logic [33:0] obs,
                     input logic [33:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall          = 1'b0;
    ex_redirect    = 1'b0;
    ex_pc_target   = 32'h0;
    ex_upd_en      = 1'b0;
    ex_upd_pc      = 32'h0;
    ex_upd_type    = 2'b00;
    ex_upd_target  = 32'h0;
    ex_upd_taken   = 1'b0;
    if2_redirect   = 1'b0;
    if2_pc         = 32'h0;
    if2_pc_fact    = 32'h0;
    if2_type_pcpre = 34'h0;
  endtask

  // Next-state of the reference: updates computed from the pre-edge
  // table, IF2 written first so the EX result wins a shared index.
  task automatic model_edge();
    bit [31:0] np;
    bit [33:0] pr;
    int        ii, xi;
    bit        iw, xw, iv, xv;
    bit [23:0] it, xt;
    bit [1:0]  ity, xty, ic, xc;
    bit [31:0] itg, xtg;
    if (!rstn) begin
      m_pc = RST_PC;
      for (int i = 0; i < 64; i++) m_v[i] = 1'b0;
      return;
    end
    pr = predict(m_pc);
    if (ex_redirect)       np = ex_pc_target;
    else if (if2_redirect) np = if2_pc_fact;
    else if (stall)        np = m_pc;
    else                   np = pr[31:0];

    ii = ix(if2_pc);
    iw = 1'b0;
    iv = m_v[ii]; it = m_tag[ii]; ity = m_ty[ii];
    itg = m_tg[ii]; ic = m_ct[ii];
    if (if2_redirect) begin
      if (if2_type_pcpre[33:32] == 2'b00) begin
        iw = 1'b1; iv = 1'b0;
      end else if (if2_pc_fact != if2_pc + 32'd4) begin
        iw = 1'b1; iv = 1'b1; it = 24'(if2_pc / 256);
        ity = if2_type_pcpre[33:32]; itg = if2_pc_fact; ic = 2'b10;
      end else if (CNT && hitm(if2_pc)) begin
        iw = 1'b1;
        if (ic != 2'b00) ic = ic - 2'b01;
      end
    end

    xi = ix(ex_upd_pc);
    xw = ex_upd_en;
    xv = m_v[xi]; xt = m_tag[xi]; xty = m_ty[xi];
    xtg = m_tg[xi]; xc = m_ct[xi];
    if (ex_upd_type == 2'b00) begin
      xv = 1'b0;
    end else begin
      if (hitm(ex_upd_pc)) begin
        if (ex_upd_taken && xc != 2'b11) xc = xc + 2'b01;
        if (!ex_upd_taken && xc != 2'b00) xc = xc - 2'b01;
      end else begin
        xc = ex_upd_taken ? 2'b10 : 2'b01;
      end
      xv = 1'b1; xt = 24'(ex_upd_pc / 256);
      xty = ex_upd_type; xtg = ex_upd_target;
    end

    if (iw) begin
      m_v[ii] = iv; m_tag[ii] = it; m_ty[ii] = ity;
      m_tg[ii] = itg; m_ct[ii] = ic;
    end
    if (xw) begin
      m_v[xi] = xv; m_tag[xi] = xt; m_ty[xi] = xty;
      m_tg[xi] = xtg; m_ct[xi] = xc;
    end
    m_pc = np;
  endtask

  task automatic cyc(input bit en = 1'b1);
    bit [31:0] p4;
    if (en) begin
      p4 = m_pc + 32'd4;
      chk("pc", {2'b00, pc}, {2'b00, m_pc});
      chk("pc_plus_4", {2'b00, pc_plus_4}, {2'b00, p4});
      chk("pred", brtype_pcpre, predict(m_pc));
    end
    model_edge();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic redir(input logic [31:0] t);
    ex_redirect  = 1'b1;
    ex_pc_target = t;
    cyc();
  endtask

  function automatic logic [31:0] rpc();
    return 32'h1c00_0000 + (32'($urandom_range(0, 127)) << 2);
  endfunction

  initial begin
    logic [33:0] expv;
    logic [31:0] p0;
    idle();
    rstn = 1'b0;
    @(negedge clk);
    cyc(1'b0);
    cyc(1'b0);
    rstn = 1'b1;

    chk("rst_pc", {2'b00, pc}, {2'b00, RST_PC});
    chk("rst_pred", brtype_pcpre, {2'b00, 32'h1c00_0004});
    cyc();
    chk("run_pc1", {2'b00, pc}, {2'b00, 32'h1c00_0004});
    cyc();
    chk("run_pc2", {2'b00, pc}, {2'b00, 32'h1c00_0008});
    chk("run_type", {32'h0, brtype_pcpre[33:32]}, 34'h0);

    ex_upd_en = 1'b1; ex_upd_pc = 32'h1c00_0010; ex_upd_type = 2'b10;
    ex_upd_target = 32'h1c00_0100; ex_upd_taken = 1'b1;
    cyc();
    redir(32'h1c00_0010);
    chk("bl_pred", brtype_pcpre, {2'b10, 32'h1c00_0100});
    cyc();
    chk("bl_next", {2'b00, pc}, {2'b00, 32'h1c00_0100});

    if2_redirect = 1'b1; if2_pc = pc; if2_pc_fact = 32'h1c00_0200;
    if2_type_pcpre = {2'b01, 32'h1c00_0200};
    ex_redirect = 1'b1; ex_pc_target = 32'h1c00_0300;
    cyc();
    chk("ex_over_if2", {2'b00, pc}, {2'b00, 32'h1c00_0300});

    ex_upd_en = 1'b1; ex_upd_pc = 32'h1c00_0020; ex_upd_type = 2'b01;
    ex_upd_target = 32'h1c00_0080; ex_upd_taken = 1'b1;
    cyc();
    redir(32'h1c00_0020);
    chk("cond_tk", brtype_pcpre, {2'b01, 32'h1c00_0080});
    for (int k = 0; k < 2; k++) begin
      ex_upd_en = 1'b1; ex_upd_pc = 32'h1c00_0020; ex_upd_type = 2'b01;
      ex_upd_target = 32'h1c00_0080; ex_upd_taken = 1'b0;
      cyc();
    end
    redir(32'h1c00_0020);
    expv = CNT ? {2'b01, 32'h1c00_0024} : {2'b01, 32'h1c00_0080};
    chk("cond_nt", brtype_pcpre, expv);

    ex_upd_en = 1'b1; ex_upd_pc = 32'h1c00_0040; ex_upd_type = 2'b11;
    ex_upd_target = 32'h1c00_0400; ex_upd_taken = 1'b1;
    if2_redirect = 1'b1; if2_pc = 32'h1c00_0140;
    if2_pc_fact = 32'h1c00_0500; if2_type_pcpre = {2'b10, 32'h1c00_0500};
    cyc();
    chk("if2_jump", {2'b00, pc}, {2'b00, 32'h1c00_0500});
    for (int k = 0; k < 3; k++) begin
      stall = 1'b1;
      if (k == 0) begin
        ex_upd_en = 1'b1; ex_upd_pc = 32'h1c00_0504; ex_upd_type = 2'b10;
        ex_upd_target = 32'h1c00_0600; ex_upd_taken = 1'b1;
      end
      cyc();
      chk("stall_pc", {2'b00, pc}, {2'b00, 32'h1c00_0500});
    end
    cyc();
    chk("post_stall", brtype_pcpre, {2'b10, 32'h1c00_0600});
    redir(32'h1c00_0040);
    chk("same_idx_ex", brtype_pcpre, {2'b11, 32'h1c00_0400});
    redir(32'h1c00_0140);
    chk("same_idx_if2", brtype_pcpre, {2'b00, 32'h1c00_0144});

    redir(32'hffff_fffc);
    chk("wrap_p4", {2'b00, pc_plus_4}, 34'h0);
    cyc();
    chk("wrap_pc", {2'b00, pc}, 34'h0);

    rstn = 1'b0; ex_redirect = 1'b1; ex_pc_target = 32'h1c00_0700;
    ex_upd_en = 1'b1; ex_upd_pc = 32'h1c00_0700; ex_upd_type = 2'b10;
    ex_upd_target = 32'h1c00_0800; ex_upd_taken = 1'b1;
    cyc();
    rstn = 1'b1;
    chk("rst2_pc", {2'b00, pc}, {2'b00, RST_PC});
    chk("rst2_pred", brtype_pcpre, {2'b00, 32'h1c00_0004});
    redir(32'h1c00_0010);
    chk("rst2_miss_a", brtype_pcpre, {2'b00, 32'h1c00_0014});
    redir(32'h1c00_0040);
    chk("rst2_miss_b", brtype_pcpre, {2'b00, 32'h1c00_0044});

    for (int n = 0; n < 600; n++) begin
      rstn  = ($urandom_range(0, 99) >= 2);
      stall = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 99) < 10) begin
        ex_redirect = 1'b1; ex_pc_target = rpc();
      end
      if ($urandom_range(0, 99) < 40) begin
        ex_upd_en = 1'b1; ex_upd_pc = rpc();
        ex_upd_type = 2'($urandom_range(0, 3));
        ex_upd_target = rpc(); ex_upd_taken = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 99) < 12) begin
        if2_redirect = 1'b1;
        p0 = ($urandom_range(0, 1) == 1) ? pc : rpc();
        if2_pc = p0;
        if2_pc_fact = ($urandom_range(0, 1) == 1) ? p0 + 32'd4 : rpc();
        if2_type_pcpre = {2'($urandom_range(0, 3)), if2_pc_fact};
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if1_btb.md
IF1_BTB -- requirements
Module: if1_btb

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, all state on rising edge
- rstn  in  1  synchronous active-low reset
- stall  in  1  hold PC (fetch back-pressure)
- ex_redirect  in  1  execute-stage mispredict redirect
- ex_pc_target  in  32  redirect PC from execute
- ex_upd_en  in  1  resolved-branch update strobe
- ex_upd_pc  in  32  PC of resolved branch
- ex_upd_type  in  2  br_type of resolved branch (00 other, 01 cond/b, 10 bl, 11 jirl)
- ex_upd_target  in  32  resolved target
- ex_upd_taken  in  1  resolved direction
- if2_redirect  in  1  IF2 predecoder flush
- if2_pc  in  32  PC of the instruction IF2 corrected
- if2_pc_fact  in  32  IF2 corrected next PC
- if2_type_pcpre  in  34  IF2 {br_type, PC_fact}
- pc  out  32  current fetch PC
- pc_plus_4  out  32  pc + 4
- brtype_pcpre  out  34  {predicted br_type, predicted next PC} for pc

REQ-002 SHALL define parameters: RESET_PC default 32'h1c00_0000, reset fetch address; BTB_ENTRIES default 64, direct-mapped entry count (power of two).

Function
REQ-003 SHALL index BTB by pc[7:2] (log2(BTB_ENTRIES) bits above bit 1) and tag by pc[31:8].
REQ-004 SHALL hold per entry: valid, tag, type[1:0], target[31:0], ctr[1:0].
REQ-005 SHALL look up combinationally from the pc register; brtype_pcpre valid in the same cycle as pc.
REQ-006 SHALL predict taken on hit when type is 10 or 11, or type 01 with ctr[1]=1.
REQ-007 SHALL drive brtype_pcpre = {type, target} if hit and taken; {type, pc+4} if hit and not taken; {2'b00, pc+4} on miss.
REQ-008 SHALL select next PC by priority: ex_redirect -> ex_pc_target; else if2_redirect -> if2_pc_fact; else stall -> hold pc; else brtype_pcpre[31:0].
REQ-009 SHALL compute all PC arithmetic modulo 2^32; 32'hffff_fffc + 4 wraps to 0.
REQ-010 SHALL apply the EX update on ex_upd_en:
- hit: overwrite type/target; ctr saturating +1 if taken, -1 if not
- miss: install valid, tag, type, target, ctr = taken ? 2'b10 : 2'b01
- ex_upd_type 00: clear valid
REQ-011 SHALL apply the IF2 update on if2_redirect:
- if2_type_pcpre[33:32]=00: clear valid at if2_pc index
- type non-zero and if2_pc_fact != if2_pc+4: install {type, target=if2_pc_fact, ctr=2'b10}
- otherwise: on hit ctr saturating -1; on miss no write
REQ-012 SHALL let the EX update win when EX and IF2 updates target the same index in the same cycle; different indices SHALL both apply.
REQ-013 SHALL make updates visible to lookup from the next cycle (no write-through bypass).
REQ-014 SHALL saturate ctr at 2'b00 and 2'b11.
REQ-015 SHALL hold pc under stall but still perform updates.

Reset
REQ-016 SHALL, with rstn low at a clock edge, set pc = RESET_PC and clear every valid bit; type/target/ctr need not reset.
REQ-017 SHALL make reset dominate redirects and updates in the same cycle; first post-reset brtype_pcpre = {2'b00, RESET_PC+4}.

Configuration
REQ-018 SHALL compile ctr storage and the REQ-006 ctr condition under macro BTB_COUNTER_EN.
REQ-019 SHALL, without BTB_COUNTER_EN, predict every hit as taken and omit all ctr updates; interface unchanged.

Structure
REQ-020 SHALL place br_type encoding constants, the BTB entry struct typedef and RESET_PC in the shared package.
REQ-021 SHALL implement the storage array with both write ports as sub-module btb_array; PC register and next-PC selection stay in if1_btb.

Verification
REQ-022 SHALL cover these directed scenarios:
- Reset, then free run: pc = 0x1c000000, 0x1c000004, 0x1c000008; brtype_pcpre[33:32] = 00
- ex_upd_en pc=0x1c000010 type=10 target=0x1c000100 taken=1; next fetch of 0x1c000010 -> brtype_pcpre = {10, 0x1c000100}; following pc = 0x1c000100
- if2_redirect and ex_redirect same cycle (if2_pc_fact=0x1c000200, ex_pc_target=0x1c000300) -> next pc = 0x1c000300
- Type 01 entry ctr=10, two not-taken EX updates -> ctr=00, prediction {01, pc+4}; with BTB_COUNTER_EN undefined -> still {01, target}
- Same-index EX and IF2 updates in one cycle -> EX contents stored; stall high 3 cycles -> pc unchanged, update still visible afterwards
- rstn low mid-run with ex_redirect high -> pc = 0x1c000000, all lookups miss
